// File: rtl/alu_multibyte_seq.sv
// Multi-precision sequencer: drives an external 8-bit ALU one limb per clock,
// chaining carry/borrow across limbs and accumulating Zero/Sign over the result.
module alu_multibyte_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Start,
    input  logic [2:0]          OpIn,
    input  logic                CinIn,
    input  logic [8*NBYTES-1:0] OperandA,
    input  logic [8*NBYTES-1:0] OperandB,
    output logic                Busy,
    output logic                Done,
    output logic [8*NBYTES-1:0] Result,
    output logic                CarryOut,
    output logic                Zero,
    output logic                Sign,
    output logic [7:0]          AluA,
    output logic [7:0]          AluB,
    output logic                AluCin,
    output logic [2:0]          AluOp,
    input  logic [7:0]          AluOut,
    input  logic                AluCout,
    input  logic                AluZero,
    input  logic                AluSign
);

    localparam int unsigned W     = 8 * NBYTES;
    localparam int unsigned IDX_W = $clog2(NBYTES);

    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       op_q;
    logic             cin_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [IDX_W-1:0] idx;
    logic             carry_reg;
    logic             zero_acc;
    logic             accept;
    logic             last;
    logic             is_arith;

    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign last     = (idx == IDX_W'(NBYTES - 1));

    // Next-state decode and ALU operand drive for the current limb
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        AluA       = 8'd0;
        AluB       = 8'd0;
        AluCin     = 1'b0;
        AluOp      = 3'd0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                for (int unsigned i = 0; i < NBYTES; i++) begin
                    if (idx == IDX_W'(i)) begin
                        AluA = a_q[i*8 +: 8];
                        AluB = b_q[i*8 +: 8];
                    end
                end
                AluOp = op_q;
                // Re-invert the chained carry for subtract so the ALU's own
                // Cin inversion sees the true borrow state.
                if (!is_arith) begin
                    AluCin = 1'b0;
                end else if (idx == '0) begin
                    AluCin = cin_q;
                end else begin
                    AluCin = carry_reg ^ op_q[2];
                end
                if (last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (Start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register with registered Busy/Done status
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_next;
            Busy  <= (state_next == S_RUN);
            Done  <= (state_next == S_DONE);
        end
    end

    // Operand latch, limb capture and flag accumulation
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            op_q      <= 3'd0;
            cin_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
            zero_acc  <= 1'b0;
            Result    <= '0;
            CarryOut  <= 1'b0;
            Zero      <= 1'b0;
            Sign      <= 1'b0;
        end else if (accept) begin
            op_q     <= OpIn;
            cin_q    <= CinIn;
            a_q      <= OperandA;
            b_q      <= OperandB;
            idx      <= '0;
            zero_acc <= 1'b1;
        end else if (state == S_RUN) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (idx == IDX_W'(i)) begin
                    Result[i*8 +: 8] <= AluOut;
                end
            end
            carry_reg <= AluCout;
            zero_acc  <= zero_acc & AluZero;
            if (last) begin
                Sign     <= AluSign;
                Zero     <= zero_acc & AluZero;
                CarryOut <= is_arith ? AluCout : 1'b0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Scoreboard bench for alu_multibyte_seq with a behavioural model of the 8-bit ALU.
module tb_alu_multibyte_seq;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op_in;
    logic         cin_in;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;
    logic         sign;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic         alu_cin;
    logic [2:0]   alu_op;
    logic [7:0]   alu_out;
    logic         alu_cout;
    logic         alu_zero;
    logic         alu_sign;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         s;
        int           id;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   push_cnt = 0;
    int   done_cnt = 0;
    int   op_id = 0;

    alu_multibyte_seq #(.NBYTES(NB)) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .Start    (start),
        .OpIn     (op_in),
        .CinIn    (cin_in),
        .OperandA (operand_a),
        .OperandB (operand_b),
        .Busy     (busy),
        .Done     (done),
        .Result   (result),
        .CarryOut (carry_out),
        .Zero     (zero),
        .Sign     (sign),
        .AluA     (alu_a),
        .AluB     (alu_b),
        .AluCin   (alu_cin),
        .AluOp    (alu_op),
        .AluOut   (alu_out),
        .AluCout  (alu_cout),
        .AluZero  (alu_zero),
        .AluSign  (alu_sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Team 8-bit ALU: sub computes A + ~B + ~Cin, so Cin=0 gives A-B and Cout=1 means no borrow
    always_comb begin
        alu_out  = 8'd0;
        alu_cout = 1'b0;
        case (alu_op)
            3'b011: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            3'b111: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, ~alu_cin};
            3'b000: alu_out = ~alu_a;
            3'b001: alu_out = alu_a & alu_b;
            3'b010: alu_out = alu_a | alu_b;
            3'b100: alu_out = alu_a ^ alu_b;
            default: alu_out = 8'd0;
        endcase
        alu_zero = (alu_out == 8'd0);
        alu_sign = alu_out[7];
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each Done pulse against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            check("done_expected", W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("op%0d_result", e.id), result, e.res);
                check($sformatf("op%0d_carry", e.id), W'(carry_out), W'(e.c));
                check($sformatf("op%0d_zero", e.id), W'(zero), W'(e.z));
                check($sformatf("op%0d_sign", e.id), W'(sign), W'(e.s));
                check($sformatf("op%0d_busy_low", e.id), W'(busy), W'(0));
            end
        end
    end

    // Present a request; returns #1 after the accepting edge
    task automatic start_op(input logic [2:0] op, input logic cin, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] er, input logic ec,
                            input logic ez, input logic es, input bit push);
        exp_t e;
        op_in     = op;
        cin_in    = cin;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        if (push) begin
            op_id++;
            e.res = er; e.c = ec; e.z = ez; e.s = es; e.id = op_id;
            exp_q.push_back(e);
            push_cnt++;
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        operand_a = '1;
        operand_b = '1;
        op_in     = 3'b010;
    endtask

    // Bounded wait for Done, sampled #1 after each edge
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("done_timeout", W'(done), W'(1));
    endtask

    task automatic run_op(input logic [2:0] op, input logic cin, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic ec,
                          input logic ez, input logic es);
        int edges;
        start_op(op, cin, a, b, er, ec, ez, es, 1'b1);
        wait_done(edges);
        check("latency", W'(edges), W'(NB));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        rst_n     = 1'b0;
        start     = 1'b0;
        op_in     = 3'd0;
        cin_in    = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy_done", W'({busy, done}), W'(0));
        check("rst_result", result, W'(0));
        check("rst_flags", W'({carry_out, zero, sign}), W'(0));
        check("rst_alu_drive", W'({alu_a, alu_b, alu_cin, alu_op}), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD with carry ripple across three limbs; explicit latency/pulse-width checks
        start_op(3'b011, 1'b0, 32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("busy_after_start", W'(busy), W'(1));
        wait_done(edges);
        check("add_latency", W'(edges), W'(NB));
        @(posedge clk);
        #1;
        check("done_one_cycle", W'(done), W'(0));
        check("result_hold", result, 32'h0100_0000);

        run_op(3'b111, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        run_op(3'b111, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        run_op(3'b111, 1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0001, 1'b1, 1'b0, 1'b0);

        // Start mid-RUN ignored, then Start in the DONE cycle chains immediately
        start_op(3'b011, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        operand_a = 32'h5555_5555;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges);
        check("midrun_latency", W'(edges), W'(NB - 2));
        start_op(3'b011, 1'b1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b1);
        check("b2b_busy", W'(busy), W'(1));
        wait_done(edges);
        check("b2b_latency", W'(edges), W'(NB));

        run_op(3'b000, 1'b1, 32'h0F0F_0000, 32'h1234_5678, 32'hF0F0_FFFF, 1'b0, 1'b0, 1'b1);
        run_op(3'b100, 1'b0, 32'hAAAA_5555, 32'hAAAA_5555, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        run_op(3'b001, 1'b0, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, 1'b0, 1'b0, 1'b0);
        run_op(3'b010, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 1'b0, 1'b0, 1'b1);
        run_op(3'b101, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b0);

        // Reset asserted at the second RUN edge aborts without Done
        start_op(3'b011, 1'b0, 32'h0101_0101, 32'h0202_0202, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy_done", W'({busy, done}), W'(0));
        check("abort_result", result, W'(0));
        check("abort_flags", W'({carry_out, zero, sign}), W'(0));
        check("abort_alu_drive", W'({alu_a, alu_b, alu_cin, alu_op}), W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", W'(done_cnt), W'(push_cnt));

        run_op(3'b011, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", W'(exp_q.size()), W'(0));
        check("done_count", W'(done_cnt), W'(push_cnt));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
